// File: rtl/fb_arb_pkg.sv
// Shared types and constants for the framebuffer access arbiter.
package fb_arb_pkg;

   localparam int FB_DATA_WIDTH  = 24;
   localparam int RGB_DATA_WIDTH = 8;

   typedef enum logic {
      FB_RGB     = 1'b0,
      FB_PALETTE = 1'b1
   } fb_target_e;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_LOCKED0 = 2'd1,
      ARB_LOCKED1 = 2'd2
   } arb_state_e;

   // One entry per accepted access travelling down the read-return pipeline.
   typedef struct packed {
      logic       valid;
      logic       requester;
      fb_target_e target;
   } rd_tag_t;

endpackage

// File: rtl/fb_rr_arbiter2.sv
// Two-way round-robin arbiter with burst lock, lock counter and forced release.
module fb_rr_arbiter2
   import fb_arb_pkg::*;
#(
   parameter int LOCK_MAX = 256
) (
   input  logic clk_pixel,
   input  logic reset,
   input  logic req0,
   input  logic req1,
   input  logic elig0,
   input  logic elig1,
   input  logic lock0,
   input  logic lock1,
   output logic gnt0,
   output logic gnt1
);

   localparam int CNT_W = $clog2(LOCK_MAX);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   arb_state_e       state, state_nxt;
   logic             last_grant, last_grant_nxt;
   logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;

   // State, round-robin pointer and lock counter registers.
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         state      <= ARB_IDLE;
         last_grant <= 1'b1;
         lock_cnt   <= '0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         lock_cnt   <= lock_cnt_nxt;
      end
   end

   // Grant selection and next-state; lock_cnt counts accepts in the current burst,
   // so the accept seen with lock_cnt == LOCK_MAX-1 is the LOCK_MAX-th and forces release.
   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      lock_cnt_nxt   = lock_cnt;
      gnt0           = 1'b0;
      gnt1           = 1'b0;
      unique case (state)
         ARB_IDLE: begin
            lock_cnt_nxt = '0;
            if (elig0 && (!elig1 || last_grant)) begin
               gnt0           = 1'b1;
               last_grant_nxt = 1'b0;
               if (lock0) begin
                  state_nxt    = ARB_LOCKED0;
                  lock_cnt_nxt = CNT_ONE;
               end
            end else if (elig1) begin
               gnt1           = 1'b1;
               last_grant_nxt = 1'b1;
               if (lock1) begin
                  state_nxt    = ARB_LOCKED1;
                  lock_cnt_nxt = CNT_ONE;
               end
            end
         end
         ARB_LOCKED0: begin
            gnt0 = elig0;
            if (!req0) begin
               state_nxt    = ARB_IDLE;
               lock_cnt_nxt = '0;
            end else if (gnt0) begin
               last_grant_nxt = 1'b0;
               if (!lock0 || lock_cnt == CNT_LAST) begin
                  state_nxt    = ARB_IDLE;
                  lock_cnt_nxt = '0;
               end else begin
                  lock_cnt_nxt = lock_cnt + 1'b1;
               end
            end
         end
         ARB_LOCKED1: begin
            gnt1 = elig1;
            if (!req1) begin
               state_nxt    = ARB_IDLE;
               lock_cnt_nxt = '0;
            end else if (gnt1) begin
               last_grant_nxt = 1'b1;
               if (!lock1 || lock_cnt == CNT_LAST) begin
                  state_nxt    = ARB_IDLE;
                  lock_cnt_nxt = '0;
               end else begin
                  lock_cnt_nxt = lock_cnt + 1'b1;
               end
            end
         end
         default: begin
            state_nxt    = ARB_IDLE;
            lock_cnt_nxt = '0;
         end
      endcase
   end

endmodule

// File: rtl/fb_access_arbiter.sv
// Shares the framebuffer rgb/palette ports between the SPI GPU path and an
// on-chip overlay writer; registered issue stage and in-order read return.
module fb_access_arbiter
   import fb_arb_pkg::*;
#(
   parameter int ADDR_WIDTH          = 17,
   parameter int PAL_ADDR_WIDTH      = 8,
   parameter int READ_LATENCY        = 1,
   parameter int PALETTE_VBLANK_ONLY = 1,
   parameter int LOCK_MAX            = 256
) (
   input  logic                      clk_pixel,
   input  logic                      reset,
   input  logic                      vblank,
   input  logic                      req0,
   input  logic                      req1,
   input  logic                      we0,
   input  logic                      we1,
   input  logic                      sel0,
   input  logic                      sel1,
   input  logic                      lock0,
   input  logic                      lock1,
   input  logic [ADDR_WIDTH-1:0]     addr0,
   input  logic [ADDR_WIDTH-1:0]     addr1,
   input  logic [FB_DATA_WIDTH-1:0]  wdata0,
   input  logic [FB_DATA_WIDTH-1:0]  wdata1,
   output logic                      gnt0,
   output logic                      gnt1,
   output logic                      rvalid0,
   output logic                      rvalid1,
   output logic [FB_DATA_WIDTH-1:0]  rdata0,
   output logic [FB_DATA_WIDTH-1:0]  rdata1,
   output logic [ADDR_WIDTH-1:0]     fb_rgb_addr,
   output logic [RGB_DATA_WIDTH-1:0] fb_rgb_in,
   output logic                      fb_wren_rgb,
   input  logic [RGB_DATA_WIDTH-1:0] fb_rgb_out,
   output logic [PAL_ADDR_WIDTH-1:0] fb_palette_addr,
   output logic [FB_DATA_WIDTH-1:0]  fb_palette_in,
   output logic                      fb_wren_palette,
   input  logic [FB_DATA_WIDTH-1:0]  fb_palette_out
);

   localparam logic PAL_HOLD = (PALETTE_VBLANK_ONLY != 0);

   logic                     elig0, elig1;
   logic                     acc, acc_req, acc_we;
   fb_target_e               acc_sel;
   logic [ADDR_WIDTH-1:0]    acc_addr;
   logic [FB_DATA_WIDTH-1:0] acc_wdata;
   rd_tag_t                  rd_tag_p [READ_LATENCY+1];
   rd_tag_t                  tag_out;
   logic [FB_DATA_WIDTH-1:0] rd_word;

   // A palette write outside vblank stalls only its own requester.
   assign elig0 = req0 && !(sel0 && we0 && PAL_HOLD && !vblank);
   assign elig1 = req1 && !(sel1 && we1 && PAL_HOLD && !vblank);

   fb_rr_arbiter2 #(
      .LOCK_MAX (LOCK_MAX)
   ) u_arb (
      .clk_pixel (clk_pixel),
      .reset     (reset),
      .req0      (req0),
      .req1      (req1),
      .elig0     (elig0),
      .elig1     (elig1),
      .lock0     (lock0),
      .lock1     (lock1),
      .gnt0      (gnt0),
      .gnt1      (gnt1)
   );

   // Select the granted requester's access; grants are one-hot.
   always_comb begin
      acc       = gnt0 | gnt1;
      acc_req   = gnt1;
      acc_we    = gnt1 ? we1 : we0;
      acc_sel   = fb_target_e'(gnt1 ? sel1 : sel0);
      acc_addr  = gnt1 ? addr1 : addr0;
      acc_wdata = gnt1 ? wdata1 : wdata0;
   end

   // Issue stage: drive the framebuffer ports one cycle after accept; enables pulse once.
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         fb_rgb_addr     <= '0;
         fb_rgb_in       <= '0;
         fb_wren_rgb     <= 1'b0;
         fb_palette_addr <= '0;
         fb_palette_in   <= '0;
         fb_wren_palette <= 1'b0;
      end else begin
         fb_wren_rgb     <= 1'b0;
         fb_wren_palette <= 1'b0;
         if (acc && acc_sel == FB_RGB) begin
            fb_rgb_addr <= acc_addr;
            fb_rgb_in   <= acc_wdata[RGB_DATA_WIDTH-1:0];
            fb_wren_rgb <= acc_we;
         end
         if (acc && acc_sel == FB_PALETTE) begin
            fb_palette_addr <= acc_addr[PAL_ADDR_WIDTH-1:0];
            fb_palette_in   <= acc_wdata;
            fb_wren_palette <= acc_we;
         end
      end
   end

   // Read tag pipeline: stage READ_LATENCY lines up with the BRAM output data.
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         for (int i = 0; i <= READ_LATENCY; i++) rd_tag_p[i] <= '0;
      end else begin
         rd_tag_p[0] <= '{valid: acc && !acc_we, requester: acc_req, target: acc_sel};
         for (int i = 1; i <= READ_LATENCY; i++) rd_tag_p[i] <= rd_tag_p[i-1];
      end
   end

   assign tag_out = rd_tag_p[READ_LATENCY];
   assign rd_word = (tag_out.target == FB_PALETTE) ? fb_palette_out
                  : {{(FB_DATA_WIDTH-RGB_DATA_WIDTH){1'b0}}, fb_rgb_out};

   // Return stage: register read data and strobe rvalid for the owning requester.
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         rdata0  <= '0;
         rdata1  <= '0;
      end else begin
         rvalid0 <= tag_out.valid && !tag_out.requester;
         rvalid1 <= tag_out.valid && tag_out.requester;
         if (tag_out.valid && !tag_out.requester) rdata0 <= rd_word;
         if (tag_out.valid && tag_out.requester)  rdata1 <= rd_word;
      end
   end

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Scoreboard bench for fb_access_arbiter: directed op lists per requester,
// expected grants/writes/reads queued by stimulus and checked by a monitor.
module tb_fb_access_arbiter;

   logic        clk_pixel = 1'b0;
   logic        reset = 1'b1;
   logic        vblank = 1'b0;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic        we0 = 1'b0, we1 = 1'b0;
   logic        sel0 = 1'b0, sel1 = 1'b0;
   logic        lock0 = 1'b0, lock1 = 1'b0;
   logic [16:0] addr0 = '0, addr1 = '0;
   logic [23:0] wdata0 = '0, wdata1 = '0;
   logic        gnt0, gnt1, rvalid0, rvalid1;
   logic [23:0] rdata0, rdata1;
   logic [16:0] fb_rgb_addr;
   logic [7:0]  fb_rgb_in;
   logic        fb_wren_rgb;
   logic [7:0]  fb_rgb_out;
   logic [7:0]  fb_palette_addr;
   logic [23:0] fb_palette_in;
   logic        fb_wren_palette;
   logic [23:0] fb_palette_out;

   always #5 clk_pixel = ~clk_pixel;

   fb_access_arbiter #(
      .ADDR_WIDTH(17), .PAL_ADDR_WIDTH(8), .READ_LATENCY(1),
      .PALETTE_VBLANK_ONLY(1), .LOCK_MAX(4)
   ) dut (
      .clk_pixel(clk_pixel), .reset(reset), .vblank(vblank),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .sel0(sel0), .sel1(sel1), .lock0(lock0), .lock1(lock1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1),
      .fb_rgb_addr(fb_rgb_addr), .fb_rgb_in(fb_rgb_in), .fb_wren_rgb(fb_wren_rgb),
      .fb_rgb_out(fb_rgb_out),
      .fb_palette_addr(fb_palette_addr), .fb_palette_in(fb_palette_in),
      .fb_wren_palette(fb_wren_palette), .fb_palette_out(fb_palette_out)
   );

   typedef struct { logic we; logic sel; logic lock; logic [16:0] addr; logic [23:0] wdata; } op_t;
   typedef struct { logic sel; logic [16:0] addr; logic [23:0] data; int due; } wr_exp_t;
   typedef struct { logic [23:0] data; int due; } rd_exp_t;

   op_t     ops0[$], ops1[$];
   int      exp_gnt[$];
   wr_exp_t exp_wr[$];
   rd_exp_t exp_rd0[$], exp_rd1[$];
   int      n_checks = 0;
   int      n_fail = 0;
   int      cyc = 0;

   // Framebuffer BRAM model with one cycle of read latency.
   function automatic logic [7:0] rgb_fn(input logic [16:0] a);
      return a[7:0] ^ 8'hC3;
   endfunction
   function automatic logic [23:0] pal_fn(input logic [7:0] a);
      return {a, ~a, 8'h5A};
   endfunction

   always @(posedge clk_pixel) begin
      fb_rgb_out     <= rgb_fn(fb_rgb_addr);
      fb_palette_out <= pal_fn(fb_palette_addr);
      cyc            <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name, input logic [31:0] act);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got 0x%0h with nothing expected (cycle %0d)", name, act, cyc);
   endtask

   // Monitor: compares every DUT event against the head of its expectation queue.
   always @(negedge clk_pixel) begin
      wr_exp_t w;
      rd_exp_t r;
      int      g;
      if (gnt0 && gnt1) unexpected("gnt_both", {30'b0, gnt1, gnt0});
      if (gnt0 || gnt1) begin
         if (exp_gnt.size() == 0) unexpected("gnt_extra", {31'b0, gnt1});
         else begin
            g = exp_gnt.pop_front();
            check("gnt_order", {31'b0, gnt1}, g);
         end
      end
      if (fb_wren_rgb || fb_wren_palette) begin
         if (exp_wr.size() == 0) unexpected("wr_extra", {30'b0, fb_wren_palette, fb_wren_rgb});
         else begin
            w = exp_wr.pop_front();
            check("wr_port", {30'b0, fb_wren_palette, fb_wren_rgb}, w.sel ? 2'b10 : 2'b01);
            check("wr_cycle", cyc, w.due);
            if (w.sel) begin
               check("wr_pal_addr", {24'b0, fb_palette_addr}, w.addr);
               check("wr_pal_data", {8'b0, fb_palette_in}, w.data);
            end else begin
               check("wr_rgb_addr", {15'b0, fb_rgb_addr}, w.addr);
               check("wr_rgb_data", {24'b0, fb_rgb_in}, w.data);
            end
         end
      end
      if (rvalid0) begin
         if (exp_rd0.size() == 0) unexpected("rd0_extra", rdata0);
         else begin
            r = exp_rd0.pop_front();
            check("rd0_data", rdata0, r.data);
            check("rd0_cycle", cyc, r.due);
         end
      end
      if (rvalid1) begin
         if (exp_rd1.size() == 0) unexpected("rd1_extra", rdata1);
         else begin
            r = exp_rd1.pop_front();
            check("rd1_data", rdata1, r.data);
            check("rd1_cycle", cyc, r.due);
         end
      end
   end

   task automatic add_op(input int n, input logic we, input logic sel, input logic lock,
                         input logic [16:0] addr, input logic [23:0] wdata);
      op_t o;
      o = '{we: we, sel: sel, lock: lock, addr: addr, wdata: wdata};
      if (n == 0) ops0.push_back(o);
      else ops1.push_back(o);
   endtask

   // Bit i of seq is the requester expected for the i-th grant.
   task automatic push_gnts(input int n, input logic [31:0] seq);
      for (int i = 0; i < n; i++) exp_gnt.push_back(int'(seq[i]));
   endtask

   task automatic push_expect(input int n, input op_t o, input bit expect_rd);
      rd_exp_t r;
      if (o.we) begin
         exp_wr.push_back('{sel: o.sel, addr: o.sel ? {9'b0, o.addr[7:0]} : o.addr,
                            data: o.sel ? o.wdata : {16'b0, o.wdata[7:0]}, due: cyc + 1});
      end else if (expect_rd) begin
         r.data = o.sel ? pal_fn(o.addr[7:0]) : {16'b0, rgb_fn(o.addr)};
         r.due  = cyc + 3;
         if (n == 0) exp_rd0.push_back(r);
         else exp_rd1.push_back(r);
      end
   endtask

   // Presents the head of each op list, holding it until granted.
   task automatic run_ops(input int vb_at, input bit expect_rd, output int cycles);
      int  k;
      op_t o;
      k = 0;
      while ((ops0.size() > 0 || ops1.size() > 0) && k < 200) begin
         vblank = (k >= vb_at);
         if (ops0.size() > 0) begin
            o = ops0[0];
            req0 = 1'b1; we0 = o.we; sel0 = o.sel; lock0 = o.lock; addr0 = o.addr; wdata0 = o.wdata;
         end else begin
            req0 = 1'b0; lock0 = 1'b0;
         end
         if (ops1.size() > 0) begin
            o = ops1[0];
            req1 = 1'b1; we1 = o.we; sel1 = o.sel; lock1 = o.lock; addr1 = o.addr; wdata1 = o.wdata;
         end else begin
            req1 = 1'b0; lock1 = 1'b0;
         end
         @(negedge clk_pixel);
         if (req0 && gnt0) begin
            o = ops0.pop_front();
            push_expect(0, o, expect_rd);
         end
         if (req1 && gnt1) begin
            o = ops1.pop_front();
            push_expect(1, o, expect_rd);
         end
         @(posedge clk_pixel);
         #1;
         k++;
      end
      req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0; vblank = 1'b1;
      if (k >= 200) begin
         n_checks++;
         n_fail++;
         $display("FAIL run_timeout: %0d ops still pending after %0d cycles", ops0.size() + ops1.size(), k);
         ops0.delete();
         ops1.delete();
      end
      cycles = k;
   endtask

   task automatic drain_and_reset();
      repeat (6) @(posedge clk_pixel);
      #1;
      reset = 1'b1;
      @(posedge clk_pixel);
      #1;
      reset = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_gnt0"}, {31'b0, gnt0}, 0);
      check({tag, "_gnt1"}, {31'b0, gnt1}, 0);
      check({tag, "_rvalid0"}, {31'b0, rvalid0}, 0);
      check({tag, "_rvalid1"}, {31'b0, rvalid1}, 0);
      check({tag, "_rdata0"}, {8'b0, rdata0}, 0);
      check({tag, "_rdata1"}, {8'b0, rdata1}, 0);
      check({tag, "_rgb_addr"}, {15'b0, fb_rgb_addr}, 0);
      check({tag, "_rgb_in"}, {24'b0, fb_rgb_in}, 0);
      check({tag, "_wren_rgb"}, {31'b0, fb_wren_rgb}, 0);
      check({tag, "_pal_addr"}, {24'b0, fb_palette_addr}, 0);
      check({tag, "_pal_in"}, {8'b0, fb_palette_in}, 0);
      check({tag, "_wren_pal"}, {31'b0, fb_wren_palette}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int k;
      repeat (2) @(posedge clk_pixel);
      #1;
      reset = 1'b0;
      @(negedge clk_pixel);
      check_all_zero("rst");
      @(posedge clk_pixel);
      #1;

      // Single rgb write, granted in the cycle it is requested.
      add_op(0, 1'b1, 1'b0, 1'b0, 17'h1ABCD, 24'h00005A);
      push_gnts(1, 32'h0);
      run_ops(0, 1'b1, k);
      check("single_wr_cycles", k, 1);
      drain_and_reset();

      // Contention: both read rgb 0..7, grants alternate starting with requester 0.
      for (int i = 0; i < 8; i++) begin
         add_op(0, 1'b0, 1'b0, 1'b0, 17'(i), 24'h0);
         add_op(1, 1'b0, 1'b0, 1'b0, 17'(i), 24'h0);
      end
      push_gnts(16, 32'h0000_AAAA);
      run_ops(0, 1'b1, k);
      check("contention_cycles", k, 16);
      drain_and_reset();

      // Palette hold-off: req1 palette write waits for vblank; req0 keeps being served.
      for (int i = 0; i < 4; i++) add_op(0, 1'b1, 1'b0, 1'b0, 17'h00300 + 17'(i), 24'h0000A0 + 24'(i));
      add_op(0, 1'b0, 1'b1, 1'b0, 17'h00022, 24'h0);
      add_op(1, 1'b1, 1'b1, 1'b0, 17'h00010, 24'hFF8000);
      push_gnts(6, 32'h0000_0020);
      run_ops(6, 1'b1, k);
      check("holdoff_cycles", k, 7);
      drain_and_reset();

      // Lock timeout with LOCK_MAX=4: 0,0,0,0,1,0,0,0,0,1,0,0,(idle),1
      for (int i = 0; i < 10; i++) add_op(0, 1'b1, 1'b0, 1'b1, 17'h00100 + 17'(i), 24'(i));
      for (int i = 0; i < 3; i++) add_op(1, 1'b1, 1'b0, 1'b0, 17'h00200 + 17'(i), 24'h000080 + 24'(i));
      push_gnts(13, 32'h0000_1210);
      run_ops(0, 1'b1, k);
      check("lock_cycles", k, 14);
      drain_and_reset();

      // Lock release: lock dropped on the 3rd access, next tie goes to req1: 0,0,0,1,0,1
      add_op(0, 1'b1, 1'b0, 1'b1, 17'h00400, 24'h000011);
      add_op(0, 1'b1, 1'b0, 1'b1, 17'h00401, 24'h000022);
      add_op(0, 1'b1, 1'b0, 1'b0, 17'h00402, 24'h000033);
      add_op(0, 1'b1, 1'b0, 1'b0, 17'h00403, 24'h000044);
      add_op(1, 1'b1, 1'b0, 1'b0, 17'h00500, 24'h000055);
      add_op(1, 1'b1, 1'b0, 1'b0, 17'h00501, 24'h000066);
      push_gnts(6, 32'h0000_0028);
      run_ops(0, 1'b1, k);
      check("release_cycles", k, 6);
      drain_and_reset();

      // Reset one cycle after the 2nd read accept: both reads are discarded.
      add_op(0, 1'b0, 1'b0, 1'b0, 17'h00155, 24'h0);
      add_op(0, 1'b0, 1'b0, 1'b0, 17'h000AA, 24'h0);
      push_gnts(2, 32'h0);
      run_ops(0, 1'b0, k);
      reset = 1'b1;
      @(posedge clk_pixel);
      #1;
      reset = 1'b0;
      @(negedge clk_pixel);
      check_all_zero("midrst");
      repeat (6) @(posedge clk_pixel);
      #1;

      check("left_gnt", exp_gnt.size(), 0);
      check("left_wr", exp_wr.size(), 0);
      check("left_rd0", exp_rd0.size(), 0);
      check("left_rd1", exp_rd1.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fb_access_arbiter.md
Name: fb_access_arbiter

Overview:
- Shares the single framebuffer write/read port set (rgb port and palette port) between two requesters: requester 0 is the SPI GPU command path, requester 1 is an on-chip overlay/console writer such as the USB host debug console.
- Round-robin arbitration, one access per cycle, with optional burst lock and a lock timeout.
- Holds off palette writes outside vertical blanking to prevent mid-frame colour tearing.
- Runs entirely in the clk_pixel domain. The framebuffer rgb and palette clocks are tied to clk_pixel at top level.

Parameters:
- ADDR_WIDTH, 17, rgb address width; the palette uses addr[PAL_ADDR_WIDTH-1:0].
- PAL_ADDR_WIDTH, 8, palette address width.
- READ_LATENCY, 1, framebuffer BRAM read latency in cycles (1..2).
- PALETTE_VBLANK_ONLY, 1, when 1, palette writes are granted only while vblank=1.
- LOCK_MAX, 256, maximum consecutive locked grants before forced release (power of 2, at least 2).

Ports:
- clk_pixel, in, 1, pixel clock.
- reset, in, 1, synchronous, active-high.
- vblank, in, 1, framebuffer vertical blanking flag (already in clk_pixel domain).
- req0 / req1, in, 1, access request; held until granted.
- we0 / we1, in, 1, 1 = write, 0 = read.
- sel0 / sel1, in, 1, target: 0 = rgb, 1 = palette.
- lock0 / lock1, in, 1, request to keep ownership for the next access.
- addr0 / addr1, in, ADDR_WIDTH, access address.
- wdata0 / wdata1, in, 24, write data; rgb uses [7:0].
- gnt0 / gnt1, out, 1, combinational grant; an access is accepted when req_n and gnt_n are both high.
- rvalid0 / rvalid1, out, 1, one-cycle read-data strobe.
- rdata0 / rdata1, out, 24, read data; rgb reads are zero-extended.
- fb_rgb_addr, out, ADDR_WIDTH, framebuffer rgb address.
- fb_rgb_in, out, 8, framebuffer rgb write data.
- fb_wren_rgb, out, 1, framebuffer rgb write enable.
- fb_rgb_out, in, 8, framebuffer rgb read data.
- fb_palette_addr, out, PAL_ADDR_WIDTH, framebuffer palette address.
- fb_palette_in, out, 24, framebuffer palette write data.
- fb_wren_palette, out, 1, framebuffer palette write enable.
- fb_palette_out, in, 24, framebuffer palette read data.

Behaviour:
- Reset: all outputs 0. State IDLE, last_grant = 1 (requester 0 wins the first tie), lock counter 0, read pipeline flushed.
- Eligibility: elig_n = req_n AND NOT (sel_n AND we_n AND PALETTE_VBLANK_ONLY AND NOT vblank).
  - Palette reads and all rgb accesses are always eligible.
  - An ineligible palette write stalls its requester only; the other requester keeps being served.
- At most one gnt per cycle. gnt_n is never asserted without elig_n.
- State machine:
  - IDLE:
    - Only one requester eligible: grant it.
    - Both eligible: grant the requester other than last_grant.
    - On accept with lock_n=1, go to LOCKED_n.
  - LOCKED_n:
    - Only requester n may be granted; the other sees gnt=0.
    - Accept with lock_n=0, req_n low, or lock counter reaching LOCK_MAX-1: return to IDLE.
    - On a forced release, last_grant = n, so the other requester wins the next tie.
    - The lock counter increments per locked accept and clears on entering IDLE.
- Access issue (registered):
  - Accept in cycle t drives the framebuffer outputs at t+1 for exactly one cycle.
  - rgb target: fb_rgb_addr = addr, fb_rgb_in = wdata[7:0], fb_wren_rgb = we.
  - Palette target: fb_palette_addr = addr[PAL_ADDR_WIDTH-1:0], fb_palette_in = wdata, fb_wren_palette = we.
  - Write enables are 0 in idle cycles. Addresses and data hold their last values.
- Read return:
  - A tag pipeline (valid, requester, target) of depth READ_LATENCY+1 tracks each accepted read.
  - rvalid_n pulses in cycle t+2+READ_LATENCY (t+3 by default), with rdata registered.
  - Fully pipelined: back-to-back reads return in order, one per cycle.
  - Writes generate no rvalid.
- vblank may fall while a palette write is pending: that write is not granted and waits for the next vblank.
- reset mid-burst: lock is dropped and in-flight reads are discarded (no rvalid).
- Requesters must not change addr, we, sel or wdata while req is high and gnt is low. The block has no internal queuing.

Decomposition:
- Package fb_arb_pkg:
  - typedef enum fb_target_e {FB_RGB, FB_PALETTE}
  - typedef enum arb_state_e {ARB_IDLE, ARB_LOCKED0, ARB_LOCKED1}
  - typedef struct rd_tag_t {valid, requester, target}
  - constants FB_DATA_WIDTH = 24, RGB_DATA_WIDTH = 8
- Sub-module fb_rr_arbiter2: 2-way round-robin with lock, lock counter and forced release. It takes elig/lock and returns gnt. The top module owns the issue registers and the read pipeline.

Test Plan:
- Single rgb write: req0 with we=1, sel=0, addr=0x1ABCD, wdata=0x5A → gnt0 in the same cycle; next cycle fb_wren_rgb=1, fb_rgb_addr=0x1ABCD, fb_rgb_in=0x5A; following cycle fb_wren_rgb=0.
- Contention: req0 and req1 both continuously issue rgb reads of addresses 0..7 with lock=0 → grants alternate 0,1,0,1…; each rvalid arrives 3 cycles after its accept with the matching fb_rgb_out value zero-extended.
- Palette hold-off: vblank=0, req1 palette write addr=0x10, wdata=0xFF8000; req0 doing rgb writes → req0 served every cycle, gnt1=0; after vblank rises, gnt1 is granted and the next cycle shows fb_wren_palette=1, fb_palette_addr=0x10.
- Lock and timeout: LOCK_MAX=4; req0 locked burst of 10 writes while req1 requests → 4 grants to 0, then 1 grant to 1, then 4 grants to 0, and so on; req1 is never starved for more than 4 cycles.
- Lock release: req0 locked for 3 accesses, then lock=0 on the 3rd → state returns to IDLE and the next tie goes to req1.
- Reset mid-operation: issue 2 rgb reads from req0, then assert reset one cycle after the 2nd accept → no rvalid0 is produced and all outputs read 0 in the cycle after reset.
